// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_param
// Brief    : Iterative radix-2 restoring divider, one quotient bit per clock,
//            valid/ready on both sides, optional two's-complement mode and
//            divide-by-zero reporting.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;     // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [WIDTH-1:0] r_rem;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] r_quo;     // quotient bits collected so far
  logic             r_qsign;
  logic             r_rsign;
  logic             r_zero;    // divisor was zero: skip the iterations
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  // Operand sign/magnitude; the most-negative value maps onto itself as an
  // unsigned number, which is why MIN / -1 wraps back to MIN.
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

  assign w_dvd_neg = signed_mode & dividend[WIDTH-1];
  assign w_dvs_neg = signed_mode & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step: the (WIDTH+1)-bit shifted remainder is compared with
  // the divisor. When it is not smaller, the true difference fits in WIDTH
  // bits, so a WIDTH-bit subtraction of the low bits is exact.
  logic [WIDTH:0]   w_rem_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_dvs});
  assign w_sub       = w_rem_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_next  = w_ge ? w_sub : w_rem_shift[WIDTH-1:0];
  assign w_quo_next  = {r_quo[WIDTH-2:0], w_ge};

  // Control FSM, datapath iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvs   <= w_dvs_mag;
            r_qsign <= w_dvd_neg ^ w_dvs_neg;
            r_rsign <= w_dvd_neg;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
            if (divisor == '0) begin
              // Keep the raw dividend: the zero-divisor remainder carries no
              // sign handling.
              r_zero <= 1'b1;
              r_dvd  <= dividend;
            end else begin
              r_zero <= 1'b0;
              r_dvd  <= w_dvd_mag;
            end
          end
        end
        S_BUSY: begin
          if (r_zero) begin
            // Zero divisor spends exactly one cycle here, no iterations.
            r_quotient  <= '1;
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + c_one;
            if (r_cnt == c_last) begin
              r_quotient  <= r_qsign ? (~w_quo_next + 1'b1) : w_quo_next;
              r_remainder <= r_rsign ? (~w_rem_next + 1'b1) : w_rem_next;
              r_dbz       <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
